// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo access arbiter: FSM encoding and shadow-count width.
package fifo_arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        INIT_CLEAR,
        INIT_WAIT,
        IDLE,
        PUSH_ISSUE,
        PUSH_WRITE,
        POP_ISSUE,
        POP_WAIT,
        SETTLE
    } arb_state_e;

endpackage

// File: rtl/fifo_access_arbiter_rr_pick2.sv
// Two-way round-robin picker; the pointer names the requester that wins a tie.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr;

    assign gnt_valid = |req;
    assign gnt_idx   = req[ptr] ? ptr : ~ptr;

    // Once a requester is served, the other one gets the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= 1'b0;
        else if (take) ptr <= ~gnt_idx;
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Serialises two writers and one reader onto a single fifo with a shadow fill count.
// Optional FIFO_ARB_LEVEL_EN adds registered fill_level/full/empty outputs.
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_SIZE  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req0,
    input  logic                  wr_req1,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    output logic                  wr_ack0,
    output logic                  wr_ack1,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_clear,
    output logic                  fifo_push,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] fifo_in_data,
`ifdef FIFO_ARB_LEVEL_EN
    output logic [CNT_W-1:0]      fill_level,
    output logic                  full,
    output logic                  empty,
`endif
    input  logic [DATA_WIDTH-1:0] fifo_out_data
);

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(FIFO_SIZE);

    arb_state_e       state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             op_pop, op_sel, prio_pop;
    logic             gnt_valid, gnt_idx;
    logic             wr_ok, rd_ok, do_push, do_pop;

    rr_pick2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({wr_req1, wr_req0}),
        .take      (do_push),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign wr_ok = gnt_valid && (count < SIZE_C);
    assign rd_ok = rd_req && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT_CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        case (state)
            INIT_CLEAR: state_next = INIT_WAIT;
            INIT_WAIT:  state_next = IDLE;
            IDLE: begin
                // Pop wins a tie only when it holds the priority token.
                if (rd_ok && (prio_pop || !wr_ok)) begin
                    do_pop     = 1'b1;
                    state_next = POP_ISSUE;
                end else if (wr_ok) begin
                    do_push    = 1'b1;
                    state_next = PUSH_ISSUE;
                end
            end
            PUSH_ISSUE: state_next = PUSH_WRITE;
            PUSH_WRITE: state_next = SETTLE;
            POP_ISSUE:  state_next = POP_WAIT;
            POP_WAIT:   state_next = SETTLE;
            SETTLE:     state_next = IDLE;
            default:    state_next = INIT_CLEAR;
        endcase
    end

    always_comb begin
        count_next = count;
        if (state == SETTLE) count_next = op_pop ? count - 1'b1 : count + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_clear   <= 1'b1;
            fifo_push    <= 1'b0;
            fifo_pop     <= 1'b0;
            fifo_in_data <= '0;
            wr_ack0      <= 1'b0;
            wr_ack1      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            count        <= '0;
            op_pop       <= 1'b0;
            op_sel       <= 1'b0;
            prio_pop     <= 1'b1;
        end else begin
            fifo_clear <= (state_next == INIT_CLEAR);
            fifo_push  <= do_push;
            fifo_pop   <= do_pop;
            if (do_push) begin
                fifo_in_data <= gnt_idx ? wr_data1 : wr_data0;
                op_sel       <= gnt_idx;
                op_pop       <= 1'b0;
                prio_pop     <= 1'b1;
            end
            if (do_pop) begin
                op_pop   <= 1'b1;
                prio_pop <= 1'b0;
            end
            wr_ack0  <= (state_next == SETTLE) && !op_pop && !op_sel;
            wr_ack1  <= (state_next == SETTLE) && !op_pop &&  op_sel;
            rd_valid <= (state == SETTLE) && op_pop;
            if (state == SETTLE && op_pop) rd_data <= fifo_out_data;
            count <= count_next;
        end
    end

`ifdef FIFO_ARB_LEVEL_EN
    assign fill_level = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            full  <= (count_next == SIZE_C);
            empty <= (count_next == '0);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter with a behavioural fifo on the fifo_* side.
module tb_fifo_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0;
    logic [7:0] wr_data0 = '0, wr_data1 = '0;
    logic       wr_ack0, wr_ack1, rd_valid;
    logic [7:0] rd_data, fifo_in_data;
    logic [7:0] fifo_out_data = '0;
    logic       fifo_clear, fifo_push, fifo_pop;
`ifdef FIFO_ARB_LEVEL_EN
    logic [15:0] fill_level;
    logic        full, empty;
`endif

    fifo_access_arbiter #(.FIFO_SIZE(8), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req0       (wr_req0),
        .wr_req1       (wr_req1),
        .wr_data0      (wr_data0),
        .wr_data1      (wr_data1),
        .wr_ack0       (wr_ack0),
        .wr_ack1       (wr_ack1),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_clear    (fifo_clear),
        .fifo_push     (fifo_push),
        .fifo_pop      (fifo_pop),
        .fifo_in_data  (fifo_in_data),
`ifdef FIFO_ARB_LEVEL_EN
        .fill_level    (fill_level),
        .full          (full),
        .empty         (empty),
`endif
        .fifo_out_data (fifo_out_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, push_cyc = 0, ack_cyc = 0;
    int n_push = 0, n_pop = 0, overlap = 0;
    bit         ack_log[$];
    bit         op_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] fq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Attached fifo: read buffer loads on the edge that ends the pop strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_clear) fq.delete();
        else begin
            if (fifo_push) fq.push_back(fifo_in_data);
            if (fifo_pop && fq.size() > 0) fifo_out_data <= fq.pop_front();
        end
    end

    always @(negedge clk) begin
        if (fifo_push) begin n_push++; op_log.push_back(1'b0); push_cyc = cyc; end
        if (fifo_pop)  begin n_pop++;  op_log.push_back(1'b1); end
        if (fifo_push && fifo_pop) overlap++;
        if (wr_ack0) begin ack_log.push_back(1'b0); ack_cyc = cyc; end
        if (wr_ack1) begin ack_log.push_back(1'b1); ack_cyc = cyc; end
        if (rd_valid) rd_log.push_back(rd_data);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_req0 = 1'b0; wr_req1 = 1'b0; rd_req = 1'b0;
        repeat (2) step();
        chk("rst_clear", fifo_clear, 1);
        chk("rst_strobes", {fifo_push, fifo_pop, wr_ack0, wr_ack1, rd_valid}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_in_data", fifo_in_data, 0);
`ifdef FIFO_ARB_LEVEL_EN
        chk("rst_level", {fill_level, full, empty}, 32'h1);
`endif
        rst_n = 1'b1;
        chk("init_clear_hi", fifo_clear, 1);
        step();
        chk("init_clear_lo", fifo_clear, 0);
        step();
        chk("init_idle", {fifo_clear, fifo_push, fifo_pop}, 0);
    endtask

    task automatic wr(input bit w, input logic [7:0] d);
        int base = ack_log.size();
        if (w) begin wr_req1 = 1'b1; wr_data1 = d; end
        else   begin wr_req0 = 1'b1; wr_data0 = d; end
        for (int i = 0; i < 30 && ack_log.size() == base; i++) step();
        chk("wr_timeout", ack_log.size() > base, 1);
        wr_req0 = 1'b0; wr_req1 = 1'b0;
    endtask

    task automatic rd(output logic [7:0] d);
        int base = rd_log.size();
        rd_req = 1'b1;
        for (int i = 0; i < 30 && rd_log.size() == base; i++) step();
        chk("rd_timeout", rd_log.size() > base, 1);
        rd_req = 1'b0;
        d = (rd_log.size() > base) ? rd_log[rd_log.size()-1] : 8'hxx;
    endtask

    initial begin
        logic [7:0] d;
        int base, pbase, obase, rbase, same;
        logic [7:0] exp_seq[8];

        // reset release and clear sequence
        do_reset();
        repeat (3) step();
        chk("rel_no_strobe", n_push + n_pop, 0);

        // single write then read back
        wr(1'b0, 8'hA5);
        chk("single_push_n", n_push, 1);
        chk("single_ack_lat", ack_cyc - push_cyc, 2);
        chk("single_ack_who", ack_log[ack_log.size()-1], 0);
        rd(d);
        chk("single_rd", d, 8'hA5);
        chk("single_pop_n", n_pop, 1);

        // contention between writers
        do_reset();
        base = ack_log.size();
        wr_data0 = 8'h11; wr_data1 = 8'h22; wr_req0 = 1'b1; wr_req1 = 1'b1;
        for (int i = 0; i < 60 && ack_log.size() < base + 4; i++) step();
        wr_req0 = 1'b0; wr_req1 = 1'b0;
        chk("rr_n_acks", ack_log.size() - base, 4);
        chk("rr_order", {ack_log[base], ack_log[base+1], ack_log[base+2], ack_log[base+3]}, 4'b0101);
        rd(d); chk("rr_rd0", d, 8'h11);
        rd(d); chk("rr_rd1", d, 8'h22);
        rd(d); chk("rr_rd2", d, 8'h11);
        rd(d); chk("rr_rd3", d, 8'h22);

        // full: ninth write waits for a pop
        do_reset();
        for (int i = 0; i < 8; i++) wr(1'b0, 8'h30 + 8'(i));
        base = ack_log.size(); pbase = n_push;
        wr_req0 = 1'b1; wr_data0 = 8'h99;
        repeat (20) step();
        chk("full_no_ack", ack_log.size() - base, 0);
        chk("full_no_push", n_push - pbase, 0);
        rd(d);
        chk("full_rd0", d, 8'h30);
        wr_req0 = 1'b1;
        for (int i = 0; i < 30 && ack_log.size() == base; i++) step();
        wr_req0 = 1'b0;
        chk("full_late_ack", ack_log.size() - base, 1);
        exp_seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h99};
        for (int i = 0; i < 8; i++) begin
            rd(d);
            chk($sformatf("drain_%0d", i), d, exp_seq[i]);
        end

        // read on empty
        pbase = n_pop; rbase = rd_log.size();
        rd_req = 1'b1;
        repeat (20) step();
        rd_req = 1'b0;
        chk("empty_no_pop", n_pop - pbase, 0);
        chk("empty_no_valid", rd_log.size() - rbase, 0);

        // mixed push/pop alternation
        do_reset();
        wr(1'b0, 8'h01);
        obase = op_log.size(); rbase = rd_log.size();
        wr_data0 = 8'h50; wr_req0 = 1'b1; rd_req = 1'b1;
        repeat (40) step();
        wr_req0 = 1'b0; rd_req = 1'b0;
        repeat (10) step();
        chk("mix_n_ops_ge8", (op_log.size() - obase) >= 8, 1);
        chk("mix_first_pop", op_log[obase], 1);
        same = 0;
        for (int i = obase + 1; i < op_log.size(); i++)
            if (op_log[i] == op_log[i-1]) same++;
        chk("mix_alternate", same, 0);
        chk("mix_rd_first", rd_log[rbase], 8'h01);
        chk("mix_rd_second", rd_log[rbase+1], 8'h50);

        // reset in PUSH_WRITE
        do_reset();
        pbase = n_push;
        wr_data0 = 8'h77; wr_req0 = 1'b1;
        for (int i = 0; i < 20 && !fifo_push; i++) step();
        chk("abort_push_seen", n_push - pbase, 1);
        step();
        chk("abort_in_write", fifo_push, 0);
        base = ack_log.size(); rbase = rd_log.size();
        do_reset();
        repeat (10) step();
        chk("abort_no_ack", ack_log.size() - base, 0);
        pbase = n_pop;
        rd_req = 1'b1;
        repeat (20) step();
        rd_req = 1'b0;
        chk("abort_count0", n_pop - pbase, 0);
        chk("abort_no_valid", rd_log.size() - rbase, 0);

        chk("no_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
